spi_master_ctrl: RTL and testbench
==================================

// Module: spi_master_ctrl
// PURPOSE
//  Master end of the team's 4-wire SPI RAM link. It generates SS_n/MOSI frames and captures MISO read data.
//  A host issues one command per start pulse: write address, write data, read address or read data.
//  The block drives the SPI slave/RAM pair on the same system clock, which is also the SPI bit clock.
//  It is the stimulus/initiator side that replaces hand-coded bench sequences.
// PARAMETERS
//  RD_LATENCY  2  cycles between the last MOSI bit of a READ_DATA frame and the first MISO bit sampled
//  GAP_CYCLES  1  minimum cycles SS_n stays high between frames (>=1)
// PORTS
//  clk       in   1  system clock; all logic on posedge
//  rst       in   1  synchronous reset, active-high
//  start     in   1  request pulse; accepted only when busy==0
//  cmd       in   2  00 WR_ADDR, 01 WR_DATA, 10 RD_ADDR, 11 RD_DATA
//  tx_byte   in   8  address or data byte sent after the command bits
//  busy      out  1  high from the accept edge until the gap completes
//  done      out  1  one-cycle pulse on the first cycle SS_n is back high
//  rx_data   out  8  byte captured from MISO (RD_DATA only); holds until the next RD_DATA completes
//  rx_valid  out  1  one-cycle pulse coincident with done, RD_DATA frames only
//  SS_n      out  1  slave select, active-low
//  MOSI      out  1  serial out, MSB first
//  MISO      in   1  serial in, MSB first
// BEHAVIOUR
//  Reset: SS_n=1, MOSI=0, busy=0, done=0, rx_valid=0, rx_data=8'h00, FSM=IDLE, counters=0.
//  All outputs are registered. The slave samples MOSI and updates MISO on the same posedge.
//  Accept: start&&!busy at edge T. cmd and tx_byte are latched. busy=1 from T.
//    start while busy is ignored (no queue).
//  Frame, cycle n = n-th cycle after T:
//    n=1       SS_n=0, MOSI=cmd[1] (slave read/write select bit)
//    n=2..3    MOSI=cmd[1], cmd[0]
//    n=4..11   MOSI=tx_byte[7..0]
//  WR_ADDR/WR_DATA/RD_ADDR: n=12 SS_n=1, MOSI=0, done=1.
//  RD_DATA: SS_n stays 0 and MOSI=0. The edge ending cycle 11+RD_LATENCY+k (k=1..8) samples MISO into rx_data[8-k].
//    Next cycle: SS_n=1, done=1, rx_valid=1.
//    rx_data updates once, at completion, from a separate shift register.
//  Gap: SS_n high for GAP_CYCLES cycles including the done cycle. busy drops on the edge ending the last gap cycle.
//    A start in the following cycle is accepted, giving back-to-back frames.
//  FSM: IDLE -> SEL(1) -> CMD(2) -> DATA(8) -> {GAP | WAIT(RD_LATENCY) -> RX(8) -> GAP} -> IDLE.
//    A single 4-bit down-counter is reloaded on each state entry.
//  RD_LATENCY=0: WAIT is skipped and MISO is sampled from the edge ending cycle 12.
//  rst mid-frame: next cycle SS_n=1, MOSI=0, busy=0, no done, no rx_valid, rx_data cleared.
//    The slave sees a truncated frame and must return to idle.
//  MISO is ignored outside RX. X on MISO outside RX must not propagate.
// STRUCTURE
//  spi_defs.vh holds the shared constants:
//    CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11
//    FSM state encodings
//    frame lengths HDR_BITS=3, PAYLOAD_BITS=8
//  One sub-module: spi_master_shifter (8-bit PISO for MOSI, 8-bit SIPO for MISO, load/shift enables).
//    The FSM and counter stay in the top.
// TESTING
//  Bench pairs this block with the existing SPI slave and its 256x8 RAM, preloaded.
//  1 WR_ADDR 8'h50 then WR_DATA 8'h90 -> MOSI bits 000_01010000, then 001_10010000; RAM[0x50]==8'h90.
//  2 RD_ADDR 8'h50 then RD_DATA 8'hFF -> rx_data==8'h90, rx_valid one pulse with done, SS_n low 11+RD_LATENCY+8 cycles.
//  3 start held high 40 cycles -> exactly one frame per busy period, gap==GAP_CYCLES, no frame overlap.
//  4 rst asserted at n=6 of a WR_DATA -> SS_n=1 next cycle, no done, RAM[0x50] unchanged.
//  5 start pulsed while busy (cmd=RD_DATA) -> ignored; the current WR frame completes normally.
//  6 RD_DATA with MISO forced X outside RX -> rx_data contains no X; read returns the preloaded RAM value.

Source files
------------

// File: rtl/spi_master_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// spi_master_ctrl_pkg
// Shared constants and types for the SPI RAM-link master:
//   - command encodings carried in the frame header
//   - frame field lengths (header bits, payload bits) and counter width
//   - FSM state encoding used by spi_master_ctrl
//   - helper that tells whether a command has a MISO receive phase
// ---------------------------------------------------------------------------
package spi_master_ctrl_pkg;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    // Header is the read/write select bit followed by the two command bits.
    localparam int HDR_BITS     = 3;
    localparam int PAYLOAD_BITS = 8;

    // One down-counter serves every state; it must hold PAYLOAD_BITS-1,
    // RD_LATENCY-1 and GAP_CYCLES-1.
    localparam int CNT_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SEL  = 3'd1,
        ST_CMD  = 3'd2,
        ST_DATA = 3'd3,
        ST_WAIT = 3'd4,
        ST_RX   = 3'd5,
        ST_GAP  = 3'd6
    } state_t;

    function automatic logic frame_has_rx(input logic [1:0] cmd);
        return cmd == CMD_RD_DATA;
    endfunction

endpackage

// File: rtl/spi_master_ctrl_shifter.sv
// ---------------------------------------------------------------------------
// spi_master_ctrl_shifter
// Datapath shift registers for the SPI master.
//   clk, rst     : system clock, synchronous active-high reset
//   load         : load load_byte into the transmit (PISO) register
//   load_byte    : payload byte to transmit, MSB first
//   piso_shift   : advance the PISO one bit (mosi_bit is the bit leaving)
//   sipo_shift   : shift miso into the receive (SIPO) register
//   miso         : serial input from the slave
//   mosi_bit     : current MSB of the PISO
//   sipo_next    : value the SIPO takes on a shift; lets the top capture the
//                  complete byte on the same edge as the final bit
// ---------------------------------------------------------------------------
module spi_master_ctrl_shifter
    import spi_master_ctrl_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [PAYLOAD_BITS-1:0] load_byte,
    input  logic                    piso_shift,
    input  logic                    sipo_shift,
    input  logic                    miso,
    output logic                    mosi_bit,
    output logic [PAYLOAD_BITS-1:0] sipo_next
);

    logic [PAYLOAD_BITS-1:0] piso_q, piso_d;
    logic [PAYLOAD_BITS-1:0] sipo_q, sipo_d;

    assign mosi_bit  = piso_q[PAYLOAD_BITS-1];
    assign sipo_next = {sipo_q[PAYLOAD_BITS-2:0], miso};

    always_comb begin
        piso_d = piso_q;
        if (load) begin
            piso_d = load_byte;
        end else if (piso_shift) begin
            piso_d = {piso_q[PAYLOAD_BITS-2:0], 1'b0};
        end
    end

    // MISO only enters the register while sipo_shift is high, so an
    // undriven line outside the receive window never reaches the data.
    always_comb begin
        sipo_d = sipo_q;
        if (sipo_shift) begin
            sipo_d = sipo_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            piso_q <= '0;
            sipo_q <= '0;
        end else begin
            piso_q <= piso_d;
            sipo_q <= sipo_d;
        end
    end

endmodule

// File: rtl/spi_master_ctrl.sv
// ---------------------------------------------------------------------------
// spi_master_ctrl
// Master end of the 4-wire SPI RAM link. One command per accepted start:
// sends a 3-bit header {cmd[1], cmd[1], cmd[0]} plus tx_byte on MOSI, and for
// RD_DATA waits RD_LATENCY cycles then captures 8 MISO bits into rx_data.
//   clk, rst   : system clock (also the SPI bit clock), sync active-high reset
//   start      : request pulse, accepted only while busy is low
//   cmd        : 00 WR_ADDR, 01 WR_DATA, 10 RD_ADDR, 11 RD_DATA
//   tx_byte    : address or data byte following the header
//   busy       : high from the accept edge until the gap completes
//   done       : one-cycle pulse on the first cycle SS_n is back high
//   rx_data    : last byte read by an RD_DATA frame
//   rx_valid   : pulse coincident with done for RD_DATA frames
//   SS_n, MOSI : slave select (active-low) and serial data out, MSB first
//   MISO       : serial data in, MSB first
// All outputs are registered; they are computed from the next FSM state.
// ---------------------------------------------------------------------------
module spi_master_ctrl
    import spi_master_ctrl_pkg::*;
#(
    parameter int RD_LATENCY = 2,
    parameter int GAP_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] cmd,
    input  logic [7:0] tx_byte,
    output logic       busy,
    output logic       done,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       SS_n,
    output logic       MOSI,
    input  logic       MISO
);

    // SEL carries the first header bit, so CMD counts the remaining ones.
    localparam logic [CNT_W-1:0] HDR_LOAD  = CNT_W'(HDR_BITS - 2);
    localparam logic [CNT_W-1:0] BYTE_LOAD = CNT_W'(PAYLOAD_BITS - 1);
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'((RD_LATENCY > 0) ? RD_LATENCY - 1 : 0);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'((GAP_CYCLES > 1) ? GAP_CYCLES - 1 : 0);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       cmd_q, cmd_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             rx_valid_q, rx_valid_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             ss_n_q, ss_n_d;
    logic             mosi_q, mosi_d;

    logic       accept;
    logic       load;
    logic       piso_shift;
    logic       sipo_shift;
    logic       mosi_bit;
    logic [7:0] sipo_next;

    assign accept     = start && !busy_q;
    assign load       = (state_q == ST_IDLE) && accept;
    // The PISO shifts as each payload bit is registered onto MOSI.
    assign piso_shift = (state_d == ST_DATA);
    // The edge ending each RX cycle samples one MISO bit.
    assign sipo_shift = (state_q == ST_RX);

    spi_master_ctrl_shifter u_shifter (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .load_byte  (tx_byte),
        .piso_shift (piso_shift),
        .sipo_shift (sipo_shift),
        .miso       (MISO),
        .mosi_bit   (mosi_bit),
        .sipo_next  (sipo_next)
    );

    // Next-state and counter. The counter is reloaded on every state entry
    // and the state advances when it reaches zero.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cmd_d   = cmd_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_SEL;
                    cnt_d   = '0;
                    cmd_d   = cmd;
                end
            end
            ST_SEL: begin
                state_d = ST_CMD;
                cnt_d   = HDR_LOAD;
            end
            ST_CMD: begin
                if (cnt_q == '0) begin
                    state_d = ST_DATA;
                    cnt_d   = BYTE_LOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DATA: begin
                if (cnt_q == '0) begin
                    if (frame_has_rx(cmd_q)) begin
                        if (RD_LATENCY > 0) begin
                            state_d = ST_WAIT;
                            cnt_d   = WAIT_LOAD;
                        end else begin
                            state_d = ST_RX;
                            cnt_d   = BYTE_LOAD;
                        end
                    end else begin
                        state_d = ST_GAP;
                        cnt_d   = GAP_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_RX;
                    cnt_d   = BYTE_LOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RX: begin
                if (cnt_q == '0) begin
                    state_d = ST_GAP;
                    cnt_d   = GAP_LOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Registered outputs derived from the state being entered.
    always_comb begin
        busy_d     = (state_d != ST_IDLE);
        ss_n_d     = (state_d == ST_IDLE) || (state_d == ST_GAP);
        done_d     = (state_d == ST_GAP) && (state_q != ST_GAP);
        rx_valid_d = (state_d == ST_GAP) && (state_q == ST_RX);
        rx_data_d  = rx_valid_d ? sipo_next : rx_data_q;
        unique case (state_d)
            ST_SEL:  mosi_d = cmd_d[1];
            // cnt_d counts 1 then 0, selecting cmd[1] then cmd[0].
            ST_CMD:  mosi_d = cmd_q[cnt_d[0]];
            ST_DATA: mosi_d = mosi_bit;
            default: mosi_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            cmd_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= 8'h00;
            ss_n_q     <= 1'b1;
            mosi_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cmd_q      <= cmd_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rx_valid_q <= rx_valid_d;
            rx_data_q  <= rx_data_d;
            ss_n_q     <= ss_n_d;
            mosi_q     <= mosi_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign rx_valid = rx_valid_q;
    assign rx_data  = rx_data_q;
    assign SS_n     = ss_n_q;
    assign MOSI     = mosi_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// ---------------------------------------------------------------------------
// tb_spi_master_ctrl
// Pairs spi_master_ctrl with a behavioural SPI slave + 256x8 RAM (preloaded
// with addr ^ 8'hA5). A vector table drives single frames; hand-written
// sequences cover held start, start while busy and reset mid-frame.
// ---------------------------------------------------------------------------
module tb_spi_master_ctrl;
    import spi_master_ctrl_pkg::*;

    localparam int RD_LAT = 2;
    localparam int GAP    = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [1:0] cmd = 2'b00;
    logic [7:0] tx_byte = 8'h00;
    logic       busy, done, rx_valid, SS_n, MOSI;
    logic [7:0] rx_data;
    logic       MISO;

    always #5 clk = ~clk;

    spi_master_ctrl #(.RD_LATENCY(RD_LAT), .GAP_CYCLES(GAP)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .cmd      (cmd),
        .tx_byte  (tx_byte),
        .busy     (busy),
        .done     (done),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .MISO     (MISO)
    );

    // ---------------- behavioural slave + RAM ----------------
    logic [7:0]  ram [0:255];
    logic [7:0]  sl_addr = 8'h00;
    logic        sl_rd = 1'b0;
    int          sl_e = 0;
    logic [10:0] sl_sh = '0;
    logic [10:0] sl_last_bits = '0;

    initial begin
        for (int a = 0; a < 256; a++) ram[a] = 8'(a) ^ 8'hA5;
        MISO = 1'bx;
    end

    always @(posedge clk) begin : slave
        int          e;
        int          idx;
        logic [10:0] bits;
        logic        is_rd;
        if (!SS_n) begin
            e     = sl_e + 1;
            bits  = {sl_sh[9:0], MOSI};
            is_rd = sl_rd;
            sl_e <= e;
            if (e <= 11) sl_sh <= bits;
            if (e == 11) begin
                sl_last_bits <= bits;
                is_rd = (bits[9:8] == CMD_RD_DATA);
                sl_rd <= is_rd;
                case (bits[9:8])
                    CMD_WR_ADDR, CMD_RD_ADDR: sl_addr <= bits[7:0];
                    CMD_WR_DATA:              ram[sl_addr] <= bits[7:0];
                    default: ;
                endcase
            end
            idx = e - 11 - RD_LAT;
            if (is_rd && idx >= 0 && idx < 8) MISO <= ram[sl_addr][7-idx];
            else                              MISO <= 1'bx;
        end else begin
            sl_e  <= 0;
            sl_rd <= 1'b0;
            MISO  <= 1'bx;
        end
    end

    // ---------------- checking helpers ----------------
    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Per-cycle observation counters, updated at each negedge.
    int   n_low = 0, n_done = 0, n_valid = 0, n_bad = 0, n_falls = 0;
    logic prev_ss = 1'b1;
    logic [7:0] last_rx = 8'h00;
    logic check_runs = 1'b0;
    int   lo_run = 0, hi_run = 0;
    logic hi_run_valid = 1'b0;

    task automatic tick();
        @(negedge clk);
        if (!SS_n) n_low++;
        if (done) begin n_done++; last_rx = rx_data; end
        if (rx_valid) n_valid++;
        if ((rx_valid && !done) || (done && !SS_n)) n_bad++;
        if (prev_ss && !SS_n) n_falls++;
        if (check_runs) begin
            if (prev_ss && !SS_n) begin
                if (hi_run_valid) chk("gap_len", hi_run, GAP + 1);
                lo_run = 0;
                hi_run = 0;
            end
            if (!prev_ss && SS_n) begin
                chk("frame_len", lo_run, 11);
                hi_run = 0;
                hi_run_valid = 1'b1;
            end
            if (SS_n) hi_run++;
            else      lo_run++;
        end
        prev_ss = SS_n;
    endtask

    task automatic wait_idle(input int bound);
        int k;
        k = 0;
        do begin
            tick();
            k++;
        end while (busy && k < bound);
        chk("idle_timeout", busy, 0);
    endtask

    int d_low, d_done, d_valid, d_bad, d_falls;
    int s_low, s_done, s_valid, s_bad, s_falls;

    task automatic snap();
        s_low = n_low; s_done = n_done; s_valid = n_valid; s_bad = n_bad; s_falls = n_falls;
    endtask

    task automatic delta();
        d_low = n_low - s_low; d_done = n_done - s_done; d_valid = n_valid - s_valid;
        d_bad = n_bad - s_bad; d_falls = n_falls - s_falls;
    endtask

    task automatic run_frame(input logic [1:0] c, input logic [7:0] b);
        snap();
        cmd = c; tx_byte = b; start = 1'b1;
        tick();
        start = 1'b0;
        wait_idle(80);
        delta();
    endtask

    typedef struct packed {
        logic [1:0]  c;
        logic [7:0]  b;
        logic [10:0] bits;
        logic        rd;
        logic [7:0]  rx;
    } vec_t;

    vec_t vecs [12];
    logic [7:0] held_rx;

    initial begin
        vecs[0]  = '{2'b00, 8'h50, 11'b000_01010000, 1'b0, 8'h00};
        vecs[1]  = '{2'b01, 8'h90, 11'b001_10010000, 1'b0, 8'h00};
        vecs[2]  = '{2'b10, 8'h50, 11'b110_01010000, 1'b0, 8'h00};
        vecs[3]  = '{2'b11, 8'hFF, 11'b111_11111111, 1'b1, 8'h90};
        vecs[4]  = '{2'b10, 8'h3C, 11'b110_00111100, 1'b0, 8'h00};
        vecs[5]  = '{2'b11, 8'h00, 11'b111_00000000, 1'b1, 8'h99};
        vecs[6]  = '{2'b10, 8'hFF, 11'b110_11111111, 1'b0, 8'h00};
        vecs[7]  = '{2'b11, 8'hFF, 11'b111_11111111, 1'b1, 8'h5A};
        vecs[8]  = '{2'b00, 8'h01, 11'b000_00000001, 1'b0, 8'h00};
        vecs[9]  = '{2'b01, 8'h00, 11'b001_00000000, 1'b0, 8'h00};
        vecs[10] = '{2'b10, 8'h01, 11'b110_00000001, 1'b0, 8'h00};
        vecs[11] = '{2'b11, 8'h55, 11'b111_01010101, 1'b1, 8'h00};

        // ---- reset state ----
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_ss_n", SS_n, 1);
        chk("rst_mosi", MOSI, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_rx_data", rx_data, 8'h00);
        rst = 1'b0;
        tick();
        $display("reset: SS_n=%b busy=%b rx_data=%h", SS_n, busy, rx_data);

        // ---- table-driven frames ----
        held_rx = 8'h00;
        for (int i = 0; i < 12; i++) begin
            run_frame(vecs[i].c, vecs[i].b);
            chk($sformatf("v%0d_bits", i), sl_last_bits, vecs[i].bits);
            chk($sformatf("v%0d_ss_low", i), d_low, vecs[i].rd ? 11 + RD_LAT + 8 : 11);
            chk($sformatf("v%0d_done", i), d_done, 1);
            chk($sformatf("v%0d_rx_valid", i), d_valid, vecs[i].rd);
            chk($sformatf("v%0d_coincide", i), d_bad, 0);
            chk($sformatf("v%0d_frames", i), d_falls, 1);
            if (vecs[i].rd) begin
                chk($sformatf("v%0d_rx_data", i), last_rx, vecs[i].rx);
                chk($sformatf("v%0d_rx_no_x", i), $isunknown(rx_data), 0);
                held_rx = vecs[i].rx;
            end else begin
                chk($sformatf("v%0d_rx_hold", i), rx_data, held_rx);
            end
            $display("vec %0d: cmd=%b tx=%h bits=%b ss_low=%0d rx=%h", i,
                     vecs[i].c, vecs[i].b, sl_last_bits, d_low, rx_data);
        end

        // ---- start held high for 40 cycles ----
        snap();
        check_runs = 1'b1; lo_run = 0; hi_run = 0; hi_run_valid = 1'b0;
        cmd = CMD_WR_ADDR; tx_byte = 8'h50; start = 1'b1;
        repeat (40) tick();
        start = 1'b0;
        wait_idle(80);
        check_runs = 1'b0;
        delta();
        chk("held_frames", d_falls, 4);
        chk("held_dones", d_done, 4);
        chk("held_overlap", d_bad, 0);
        $display("held start: frames=%0d dones=%0d", d_falls, d_done);

        // ---- start pulsed while busy is ignored ----
        run_frame(CMD_WR_ADDR, 8'h60);
        snap();
        cmd = CMD_WR_DATA; tx_byte = 8'h77; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        cmd = CMD_RD_DATA; tx_byte = 8'hFF; start = 1'b1;
        tick();
        start = 1'b0; cmd = 2'b00; tx_byte = 8'h00;
        wait_idle(80);
        repeat (4) tick();
        delta();
        chk("busy_start_bits", sl_last_bits, 11'b001_01110111);
        chk("busy_start_ss_low", d_low, 11);
        chk("busy_start_frames", d_falls, 1);
        chk("busy_start_done", d_done, 1);
        chk("busy_start_valid", d_valid, 0);
        run_frame(CMD_RD_ADDR, 8'h60);
        run_frame(CMD_RD_DATA, 8'hFF);
        chk("busy_start_readback", last_rx, 8'h77);
        $display("start while busy: frames=%0d readback=%h", d_falls, last_rx);

        // ---- reset at n=6 of a WR_DATA frame ----
        run_frame(CMD_WR_ADDR, 8'h50);
        snap();
        cmd = CMD_WR_DATA; tx_byte = 8'h33; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        chk("midrst_ss_n", SS_n, 1);
        chk("midrst_mosi", MOSI, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_rx_valid", rx_valid, 0);
        chk("midrst_rx_data", rx_data, 8'h00);
        rst = 1'b0;
        repeat (5) tick();
        delta();
        chk("midrst_no_done", d_done, 0);
        chk("midrst_ram", ram[8'h50], 8'h90);
        run_frame(CMD_RD_ADDR, 8'h50);
        run_frame(CMD_RD_DATA, 8'hFF);
        chk("midrst_readback", last_rx, 8'h90);
        chk("midrst_rx_no_x", $isunknown(rx_data), 0);
        $display("reset mid-frame: readback=%h", last_rx);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
